// File: rtl/fp_pkg.sv
// Shared types and default widths for the sequential half-precision-style adder.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 5;
  localparam int unsigned MAN_W_DEF = 10;
  localparam int unsigned BIAS_DEF  = 15;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ALIGN,
    ADDSUB,
    NORM,
    ROUND,
    FIN
  } state_t;

  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;

endpackage

// File: rtl/fp_round.sv
// Round-to-nearest-even with carry renormalisation, then overflow/underflow
// saturation to infinity or signed zero.
module fp_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W   = EXP_W_DEF,
  parameter int unsigned MAN_W   = MAN_W_DEF,
  parameter int unsigned EXP_MAX = 31
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic        [MAN_W:0]    mant_i,
  input  grs_t                     grs_i,
  output logic        [EXP_W+MAN_W:0] result_o
);

  localparam int unsigned EW2 = EXP_W + 2;
  localparam int unsigned MW2 = MAN_W + 2;
  localparam logic signed [EW2-1:0] EXP_INF = EW2'(EXP_MAX);

  logic                  inc;
  logic [MW2-1:0]        sum;
  logic signed [EW2-1:0] exp_r;
  logic [MAN_W-1:0]      frac;

  always_comb begin
    inc    = grs_i.g & (grs_i.r | grs_i.s | mant_i[0]);
    sum    = {1'b0, mant_i} + MW2'(inc);
    exp_r  = exp_i;
    frac   = sum[MAN_W-1:0];
    // A carry out of the hidden bit leaves 1.000..0, so only the exponent moves
    if (sum[MW2-1]) begin
      exp_r = exp_i + EW2'(1);
      frac  = sum[MAN_W:1];
    end
    if (exp_r >= EXP_INF) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r[EW2-1] || (exp_r == EW2'(0))) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      result_o = {sign_i, exp_r[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract: one alignment shift and one
// normalisation shift per clock, flush-to-zero, round-to-nearest-even.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  parameter int unsigned BIAS  = BIAS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned W       = 1 + EXP_W + MAN_W;
  localparam int unsigned EW2     = EXP_W + 2;
  localparam int unsigned XW      = MAN_W + 5;
  localparam int unsigned CNT_W   = $clog2(MAN_W + 4);
  localparam int unsigned EXP_MAX = 2 * BIAS + 1;

  state_t                state_q, state_d;
  logic [W-1:0]          opa_q, opa_d, opb_q, opb_d;
  logic                  sa_q, sa_d, sb_q, sb_d, sign_q, sign_d;
  logic [EXP_W-1:0]      ea_q, ea_d, diff_q, diff_d;
  logic [MAN_W:0]        ma_q, ma_d, mb_q, mb_d;
  grs_t                  grs_q, grs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [EW2-1:0] exp_q, exp_d;
  logic [W-1:0]          pend_q, pend_d, result_q, result_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [EXP_W-1:0]      ua_e, ub_e;
  logic [MAN_W:0]        ua_m, ub_m, nm;
  logic                  swap, eff_sub;
  logic [XW-1:0]         sum_ext;
  grs_t                  ngrs;
  logic [W-1:0]          round_res;

  fp_round #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .EXP_MAX(EXP_MAX)
  ) u_round (
    .sign_i  (sign_q),
    .exp_i   (exp_q),
    .mant_i  (ma_q),
    .grs_i   (grs_q),
    .result_o(round_res)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    diff_d   = diff_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    grs_d    = grs_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    pend_d   = pend_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    nm       = '0;
    ngrs     = '0;

    // Zero exponent flushes the operand to zero; otherwise restore hidden bit
    ua_e = opa_q[W-2:MAN_W];
    ub_e = opb_q[W-2:MAN_W];
    ua_m = (ua_e == '0) ? '0 : {1'b1, opa_q[MAN_W-1:0]};
    ub_m = (ub_e == '0) ? '0 : {1'b1, opb_q[MAN_W-1:0]};
    swap = {ub_e, ub_m} > {ua_e, ua_m};

    eff_sub = sa_q ^ sb_q;
    sum_ext = eff_sub ? ({1'b0, ma_q, 3'b000} - {1'b0, mb_q, grs_q})
                      : ({1'b0, ma_q, 3'b000} + {1'b0, mb_q, grs_q});

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = op_a;
          opb_d   = {op_b[W-1] ^ sub, op_b[W-2:0]};
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        if (swap) begin
          sa_d   = opb_q[W-1];
          sb_d   = opa_q[W-1];
          ea_d   = ub_e;
          ma_d   = ub_m;
          mb_d   = ua_m;
          diff_d = ub_e - ua_e;
        end else begin
          sa_d   = opa_q[W-1];
          sb_d   = opb_q[W-1];
          ea_d   = ua_e;
          ma_d   = ua_m;
          mb_d   = ub_m;
          diff_d = ua_e - ub_e;
        end
        grs_d   = '0;
        cnt_d   = '0;
        state_d = (diff_d == '0) ? ADDSUB : ALIGN;
      end
      ALIGN: begin
        // Once every original bit has reached sticky, further shifts are no-ops
        mb_d   = mb_q >> 1;
        grs_d  = '{g: mb_q[0], r: grs_q.g, s: grs_q.r | grs_q.s};
        diff_d = diff_q - EXP_W'(1);
        cnt_d  = cnt_q + CNT_W'(1);
        if ((diff_q == EXP_W'(1)) || (cnt_q == CNT_W'(MAN_W + 2))) begin
          state_d = ADDSUB;
        end
      end
      ADDSUB: begin
        if (sum_ext[XW-1]) begin
          nm    = sum_ext[XW-1:4];
          ngrs  = '{g: sum_ext[3], r: sum_ext[2], s: |sum_ext[1:0]};
          exp_d = EW2'(ea_q) + EW2'(1);
        end else begin
          nm    = sum_ext[XW-2:3];
          ngrs  = grs_t'(sum_ext[2:0]);
          exp_d = EW2'(ea_q);
        end
        ma_d   = nm;
        grs_d  = ngrs;
        sign_d = sa_q;
        // Exact cancellation is +0; only a same-sign add of two zeros keeps the sign
        if (sum_ext == '0) begin
          pend_d  = {~eff_sub & sa_q, {(W-1){1'b0}}};
          state_d = FIN;
        end else if (nm[MAN_W]) begin
          state_d = ROUND;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        ma_d  = {ma_q[MAN_W-1:0], grs_q.g};
        grs_d = '{g: grs_q.r, r: grs_q.s, s: grs_q.s};
        exp_d = exp_q - EW2'(1);
        if (ma_q[MAN_W-1]) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        pend_d  = round_res;
        state_d = FIN;
      end
      FIN: begin
        result_d = pend_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      diff_q   <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      grs_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      pend_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      diff_q   <= diff_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      grs_q    <= grs_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed half-precision vectors,
// busy-start rejection, mid-operation reset and back-to-back starts.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sub;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] result;
  logic        busy;
  logic        done;

  fp_addsub_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .op_a  (op_a),
    .op_b  (op_b),
    .result(result),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] res;
    int          c0;
    int          bound;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;
  exp_t mon_e;
  int   mon_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic int lat_bound(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, d;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    d  = (ea > eb) ? ea - eb : eb - ea;
    if (d > 13) d = 13;
    return 4 + d + 10 + 2;
  endfunction

  // Monitor: every rising edge of done retires the oldest expected result
  always @(negedge clk) begin
    if (reset) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got result %h expected no completion", result);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_result"}, result, mon_e.res);
          check({mon_e.name, "_busy_low"}, 16'(busy), 16'd0);
          mon_lat = cyc - mon_e.c0;
          checks++;
          if (mon_lat < 1 || mon_lat > mon_e.bound) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles expected 1..%0d", mon_e.name, mon_lat, mon_e.bound);
          end
        end
      end
      done_prev = done;
    end
  end

  // Called just after a negedge; start is sampled on the following posedge
  task automatic issue(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] want, input bit push);
    exp_t e;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    if (push) begin
      e.name  = name;
      e.res   = want;
      e.c0    = cyc;
      e.bound = lat_bound(a, b);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy_rise"}, 16'(busy), 16'd1);
    check({name, "_done_fall"}, 16'(done), 16'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, n);
    end
  endtask

  task automatic run(input string name, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input logic [15:0] want);
    issue(name, a, b, s, want, 1'b1);
    wait_done(name);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    check("rst_result", result, 16'h0000);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    reset = 1'b0;
    @(negedge clk);

    run("one_plus_one",     16'h3C00, 16'h3C00, 1'b0, 16'h4000);
    run("one_minus_one",    16'h3C00, 16'h3C00, 1'b1, 16'h0000);
    run("cancel_norm",      16'h3C00, 16'h3BFF, 1'b1, 16'h1000);
    run("tie_even",         16'h3C00, 16'h1000, 1'b0, 16'h3C00);
    run("tie_up",           16'h3C01, 16'h1000, 1'b0, 16'h3C02);
    run("overflow",         16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
    run("zero_plus_neg",    16'h0000, 16'hBC00, 1'b0, 16'hBC00);
    run("zero_minus_one",   16'h0000, 16'h3C00, 1'b1, 16'hBC00);
    run("negz_plus_negz",   16'h8000, 16'h8000, 1'b0, 16'h8000);
    run("negz_minus_z",     16'h8000, 16'h0000, 1'b1, 16'h8000);
    run("one_plus_negone",  16'h3C00, 16'hBC00, 1'b0, 16'h0000);
    run("two_minus_one",    16'h4000, 16'h3C00, 1'b1, 16'h3C00);
    run("one_minus_two",    16'h3C00, 16'h4000, 1'b1, 16'hBC00);

    // Starts presented while busy must not disturb the running operation
    issue("busy_ignore", 16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_a  = 16'h7BFF;
      op_b  = 16'h7BFF;
      sub   = 1'b1;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore");

    // Reset while the long alignment is in progress
    issue("abort", 16'h6000, 16'h1000, 1'b0, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_result", result, 16'h0000);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_idle_busy", 16'(busy), 16'd0);
    check("abort_idle_done", 16'(done), 16'd0);
    check("abort_idle_result", result, 16'h0000);

    run("recover",          16'h3C00, 16'h3C00, 1'b0, 16'h4000);
    run("back_to_back",     16'h4000, 16'h3C00, 1'b1, 16'h3C00);

    @(negedge clk);
    check("scoreboard_empty", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_addsub_seq.md
FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  EXP_W    5    exponent field width
  MAN_W    10   stored mantissa width, hidden bit excluded
  BIAS     15   exponent bias, 2^(EXP_W-1)-1
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk      in   1                clock, all state rises on posedge
  reset    in   1                asynchronous, active-high
  start    in   1                launch operation when idle
  sub      in   1                0 = a+b, 1 = a-b
  op_a     in   1+EXP_W+MAN_W    operand A {sign,exp,man}
  op_b     in   1+EXP_W+MAN_W    operand B
  result   out  1+EXP_W+MAN_W    rounded result, held until next start
  busy     out  1                high from start acceptance until done
  done     out  1                level; high from completion until next accepted start
REQ-003 One clock (clk); reset asynchronous and active-high.

Function
REQ-004 FSM states: IDLE, UNPACK, ALIGN, ADDSUB, NORM, ROUND, FIN.
REQ-005 IDLE: start=1 captures op_a, op_b and sub; effective B sign = sign_b XOR sub; done falls and busy rises next cycle; go to UNPACK.
REQ-006 start while busy is ignored; captured operands stay stable.
REQ-007 UNPACK: exp==0 means zero (flush-to-zero, no subnormals); otherwise prepend hidden 1; swap so the larger magnitude is A (exp, then mantissa); go to ALIGN.
REQ-008 ALIGN: shift the smaller mantissa right 1 bit per cycle until exponents match; guard/round/sticky track shifted-out bits; sticky ORs everything below round.
REQ-009 After MAN_W+3 shifts the smaller mantissa becomes zero with sticky=OR of its original bits; ALIGN then ends without further cycles.
REQ-010 ADDSUB: same effective sign adds; different signs subtract smaller from larger, GRS included; result sign = sign of larger magnitude.
REQ-011 Add carry-out: shift right 1, exp+1, shifted bit enters GRS.
REQ-012 NORM: while hidden-bit position is 0 and result nonzero, shift left 1 per cycle (guard shifts in), exp-1 per cycle.
REQ-013 Exact cancellation (mantissa and GRS all zero): result +0 (all bits 0), skip to FIN.
REQ-014 ROUND: round-to-nearest-even; increment when G & (R|S|LSB); a mantissa carry renormalises, exp+1.
REQ-015 Exponent reaching 2^EXP_W-1: result = sign, exp all ones, mantissa 0 (infinity). Exponent reaching 0 or below: signed zero.
REQ-016 Either input zero: result = other operand, B sign-adjusted per sub, still via full FSM; both zero: +0, or -0 when both effective signs are negative.
REQ-017 FIN: drive result, done=1, busy=0, return to IDLE; start is accepted in the same cycle done rises.
REQ-018 Latency from start to done: at most 4 + min(exp diff, MAN_W+3) + MAN_W + 2 cycles.
REQ-019 Inputs with exponent all ones are treated as ordinary finite values; inf/NaN are not handled.

Reset
REQ-020 reset=1 forces IDLE; result=0, busy=0, done=0, all internal registers 0, regardless of state.
REQ-021 Reset mid-operation abandons the operation; no partial result reaches result.

Structure
REQ-022 Package fp_pkg holds the state enum, the EXP_W/MAN_W/BIAS defaults and a GRS struct type.
REQ-023 Rounding and renormalisation after rounding SHALL be the combinational sub-module fp_round, instantiated once.

Verification (EXP_W=5, MAN_W=10)
REQ-024 0x3C00 + 0x3C00, sub=0 -> 0x4000, done high, busy low.
REQ-025 0x3C00 - 0x3C00, sub=1 -> 0x0000; 0x3C00 - 0x3BFF -> 0x1000 after multi-cycle NORM.
REQ-026 0x3C00 + 0x1000 -> 0x3C00 (tie, even kept); 0x3C01 + 0x1000 -> 0x3C02 (tie, round up).
REQ-027 0x7BFF + 0x7BFF -> 0x7C00 (overflow); 0x0000 + 0xBC00 -> 0xBC00.
REQ-028 Reset asserted during ALIGN of 0x6000 + 0x1000 -> result 0, done 0, busy 0, FSM IDLE; start asserted while busy is ignored; start in the cycle after done rises is accepted.
